// File: rtl/rv32i_ctrl_fsm.sv
// rv32i_ctrl_fsm -- multi-cycle RV32I control unit.
//
// Walks each instruction through FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB)
// and drives the datapath strobes.  Memory handshakes are guarded by a wait
// counter; a missing ack, a SYSTEM opcode or an unknown opcode parks the FSM
// in TRAP until rst.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   imem_req / imem_ack instruction fetch handshake, instr = fetched word
//   dmem_req / dmem_ack data access handshake, dmem_we = store strobe
//   alu_op, alu_src_imm ALU operation and operand-B select (1 = immediate)
//   alu_zero, alu_lsb   ALU result == 0 and result bit 0 (branch decisions)
//   ir_we               external instruction register load
//   rf_we, wb_sel       register file write enable and writeback source
//   pc_we, pc_sel       PC update enable and next-PC source
//   state, trap         current state code and trap indicator
module rv32i_ctrl_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] instr,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic [5:0]  alu_op,
  output logic        alu_src_imm,
  input  logic        alu_zero,
  input  logic        alu_lsb,
  output logic        ir_we,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [2:0]  state,
  output logic        trap
);

  // alu_ops encoding
  localparam logic [5:0] OP_ADD  = 6'd0,  OP_SUB   = 6'd1,  OP_SLL   = 6'd2;
  localparam logic [5:0] OP_SLT  = 6'd3,  OP_SLTU  = 6'd4,  OP_XOR   = 6'd5;
  localparam logic [5:0] OP_SRL  = 6'd6,  OP_SRA   = 6'd7,  OP_OR    = 6'd8;
  localparam logic [5:0] OP_AND  = 6'd9,  OP_ADDI  = 6'd10, OP_SLTI  = 6'd11;
  localparam logic [5:0] OP_SLTIU= 6'd12, OP_XORI  = 6'd13, OP_ORI   = 6'd14;
  localparam logic [5:0] OP_ANDI = 6'd15, OP_BYPASS= 6'd16, OP_JALR  = 6'd17;
  localparam logic [5:0] OP_NOP  = 6'd18, OP_INVALID = 6'd19;

  // Last waiting cycle: the counter holds TIMEOUT_CYCLES-1 on the final
  // cycle in which an ack is still accepted.
  localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXECUTE = 3'd2,
    ST_MEM   = 3'd3, ST_WB     = 3'd4, ST_TRAP    = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_LUI, C_AUIPC, C_JAL, C_B, C_LW, C_JALR, C_I, C_SW, C_R, C_SYS, C_BAD
  } iclass_t;

  state_t      r_state, w_state_next;
  logic [31:0] r_instr;
  logic [15:0] r_wait_cnt;
  iclass_t     w_class;
  logic [5:0]  w_ex_op;
  logic [2:0]  w_funct3;
  logic [4:0]  w_rd;
  logic        w_f7b5, w_limit, w_waiting, w_taken, w_br_valid;
  logic        w_unused_instr;

  assign w_funct3 = r_instr[14:12];
  assign w_rd     = r_instr[11:7];
  assign w_f7b5   = r_instr[30];
  assign w_limit  = (r_wait_cnt == WAIT_LIMIT);
  assign w_waiting = ((r_state == ST_FETCH) && !imem_ack) ||
                     ((r_state == ST_MEM) && !dmem_ack);
  // Immediate and register-number fields are consumed by the datapath only.
  assign w_unused_instr = ^{r_instr[31], r_instr[29:15]};
  assign state = rst ? ST_FETCH : r_state;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_FETCH;
      r_wait_cnt <= '0;
      r_instr    <= '0;
    end else begin
      r_state <= w_state_next;
      // Any state change restarts the count, which covers entry to FETCH/MEM.
      if (w_state_next != r_state) r_wait_cnt <= '0;
      else if (w_waiting)          r_wait_cnt <= r_wait_cnt + 16'd1;
      if ((r_state == ST_FETCH) && imem_ack) r_instr <= instr;
    end
  end

  always_comb begin
    w_class = C_BAD;
    case (r_instr[6:0])
      7'b0110111: w_class = C_LUI;
      7'b0010111: w_class = C_AUIPC;
      7'b1101111: w_class = C_JAL;
      7'b1100011: w_class = C_B;
      7'b0000011: if (w_funct3 == 3'b010) w_class = C_LW;
      7'b1100111: w_class = C_JALR;
      7'b0010011: w_class = C_I;
      7'b0100011: if (w_funct3 == 3'b010) w_class = C_SW;
      7'b0110011: w_class = C_R;
      7'b1110011: w_class = C_SYS;
      default:    w_class = C_BAD;
    endcase
  end

  // Branch outcome; funct3 010/011 are not branches.
  always_comb begin
    w_taken    = 1'b0;
    w_br_valid = 1'b1;
    case (w_funct3)
      3'b000:         w_taken = alu_zero;
      3'b001:         w_taken = !alu_zero;
      3'b100, 3'b110: w_taken = alu_lsb;
      3'b101, 3'b111: w_taken = !alu_lsb;
      default:        w_br_valid = 1'b0;
    endcase
  end

  always_comb begin
    w_ex_op = OP_INVALID;
    case (w_class)
      C_R: begin
        case (w_funct3)
          3'b000:  w_ex_op = w_f7b5 ? OP_SUB : OP_ADD;
          3'b001:  w_ex_op = OP_SLL;
          3'b010:  w_ex_op = OP_SLT;
          3'b011:  w_ex_op = OP_SLTU;
          3'b100:  w_ex_op = OP_XOR;
          3'b101:  w_ex_op = w_f7b5 ? OP_SRA : OP_SRL;
          3'b110:  w_ex_op = OP_OR;
          default: w_ex_op = OP_AND;
        endcase
      end
      C_I: begin
        case (w_funct3)
          3'b000:  w_ex_op = OP_ADDI;
          3'b001:  w_ex_op = OP_SLL;
          3'b010:  w_ex_op = OP_SLTI;
          3'b011:  w_ex_op = OP_SLTIU;
          3'b100:  w_ex_op = OP_XORI;
          3'b101:  w_ex_op = w_f7b5 ? OP_SRA : OP_SRL;
          3'b110:  w_ex_op = OP_ORI;
          default: w_ex_op = OP_ANDI;
        endcase
      end
      C_LW, C_SW, C_AUIPC, C_JAL: w_ex_op = OP_ADD;
      C_LUI:  w_ex_op = OP_BYPASS;
      C_JALR: w_ex_op = OP_JALR;
      C_B: begin
        case (w_funct3)
          3'b000, 3'b001: w_ex_op = OP_SUB;
          3'b100, 3'b101: w_ex_op = OP_SLT;
          3'b110, 3'b111: w_ex_op = OP_SLTU;
          default:        w_ex_op = OP_INVALID;
        endcase
      end
      default: w_ex_op = OP_INVALID;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    imem_req     = 1'b0;
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    alu_op       = OP_NOP;
    alu_src_imm  = 1'b0;
    ir_we        = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = 2'b00;
    pc_we        = 1'b0;
    pc_sel       = 2'b00;
    trap         = 1'b0;
    case (r_state)
      ST_FETCH: begin
        imem_req = 1'b1;
        // Ack wins over the timeout on the limit cycle.
        if (imem_ack) begin
          ir_we        = 1'b1;
          w_state_next = ST_DECODE;
        end else if (w_limit) begin
          w_state_next = ST_TRAP;
        end
      end
      ST_DECODE: begin
        w_state_next = ((w_class == C_SYS) || (w_class == C_BAD)) ? ST_TRAP : ST_EXECUTE;
      end
      ST_EXECUTE: begin
        alu_op      = w_ex_op;
        alu_src_imm = (w_class == C_I) || (w_class == C_LW) || (w_class == C_SW) ||
                      (w_class == C_LUI) || (w_class == C_AUIPC) || (w_class == C_JALR);
        case (w_class)
          C_LW, C_SW: w_state_next = ST_MEM;
          C_B: begin
            if (w_br_valid) begin
              pc_we        = 1'b1;
              pc_sel       = w_taken ? 2'b01 : 2'b00;
              w_state_next = ST_FETCH;
            end else begin
              w_state_next = ST_TRAP;
            end
          end
          default: w_state_next = ST_WB;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (w_class == C_SW);
        if (dmem_ack) begin
          if (w_class == C_SW) begin
            pc_we        = 1'b1;
            w_state_next = ST_FETCH;
          end else begin
            w_state_next = ST_WB;
          end
        end else if (w_limit) begin
          w_state_next = ST_TRAP;
        end
      end
      ST_WB: begin
        rf_we        = (w_rd != 5'd0);
        wb_sel       = (w_class == C_LW) ? 2'b01 :
                       ((w_class == C_JAL) || (w_class == C_JALR)) ? 2'b10 : 2'b00;
        pc_we        = 1'b1;
        pc_sel       = (w_class == C_JAL) ? 2'b01 : (w_class == C_JALR) ? 2'b10 : 2'b00;
        w_state_next = ST_FETCH;
      end
      ST_TRAP: trap = 1'b1;
      default: w_state_next = ST_TRAP;
    endcase
    // While reset is held the outputs show an idle FETCH.
    if (rst) begin
      imem_req    = 1'b1;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      alu_op      = OP_NOP;
      alu_src_imm = 1'b0;
      ir_we       = 1'b0;
      rf_we       = 1'b0;
      wb_sel      = 2'b00;
      pc_we       = 1'b0;
      pc_sel      = 2'b00;
      trap        = 1'b0;
    end
  end

endmodule

// File: tb/tb_rv32i_ctrl_fsm.sv
// Self-checking bench for rv32i_ctrl_fsm: directed vector table, a few
// hand-written reset/trap sequences and randomized instructions checked
// against a per-instruction effect model.
module tb_rv32i_ctrl_fsm;
  localparam int TO = 4;

  logic        clk, rst;
  logic        imem_req, imem_ack, dmem_req, dmem_we, dmem_ack;
  logic [31:0] instr;
  logic [5:0]  alu_op;
  logic        alu_src_imm, alu_zero, alu_lsb, ir_we, rf_we, pc_we, trap;
  logic [1:0]  wb_sel, pc_sel;
  logic [2:0]  state;

  rv32i_ctrl_fsm #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(imem_ack), .instr(instr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack), .alu_op(alu_op),
    .alu_src_imm(alu_src_imm), .alu_zero(alu_zero), .alu_lsb(alu_lsb), .ir_we(ir_we),
    .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_sel(pc_sel), .state(state),
    .trap(trap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Per-instruction effects. alu = 63: never in EXECUTE; psel/wb = 3: no pulse.
  typedef struct {
    int cyc; int trp; int alu; int imm; int pcn; int psel;
    int rfn; int wb;  int dmn; int wen; int irn;
  } res_t;

  typedef struct {
    logic [31:0] ins; int fd; int md; bit z; bit l; res_t e;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic res_t blank();
    res_t r;
    r.cyc = 0; r.trp = 0; r.alu = 63; r.imm = 0; r.pcn = 0; r.psel = 3;
    r.rfn = 0; r.wb = 3; r.dmn = 0; r.wen = 0; r.irn = 0;
    return r;
  endfunction

  function automatic vec_t mk(logic [31:0] ins, int fd, int md, bit z, bit l,
                              int cyc, int trp, int alu, int imm, int pcn, int psel,
                              int rfn, int wb, int dmn, int wen, int irn);
    vec_t v;
    v.ins = ins; v.fd = fd; v.md = md; v.z = z; v.l = l;
    v.e.cyc = cyc; v.e.trp = trp; v.e.alu = alu; v.e.imm = imm; v.e.pcn = pcn;
    v.e.psel = psel; v.e.rfn = rfn; v.e.wb = wb; v.e.dmn = dmn; v.e.wen = wen;
    v.e.irn = irn;
    return v;
  endfunction

  // Effect model: what one instruction must do, given ack delays fd/md.
  function automatic res_t model(logic [31:0] ins, int fd, int md, bit z, bit l);
    res_t e = blank();
    int fetch = fd + 1;
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    bit alt = ins[30];
    bit rd_nz = (ins[11:7] != 5'd0);
    int r_tab[8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int i_tab[8] = '{10, 2, 11, 12, 13, 6, 14, 15};
    bit is_r   = (op == 7'h33), is_i = (op == 7'h13), is_lui = (op == 7'h37);
    bit is_aui = (op == 7'h17), is_jal = (op == 7'h6F), is_jalr = (op == 7'h67);
    bit is_b   = (op == 7'h63);
    bit is_lw  = (op == 7'h03) && (f3 == 3'd2);
    bit is_sw  = (op == 7'h23) && (f3 == 3'd2);
    if (fd >= TO) begin e.trp = 1; e.cyc = TO; return e; end
    e.irn = 1;
    if (!(is_r || is_i || is_lui || is_aui || is_jal || is_jalr || is_b || is_lw || is_sw)) begin
      e.trp = 1; e.cyc = fetch + 1; return e;
    end
    e.imm = (is_i || is_lw || is_sw || is_lui || is_aui || is_jalr) ? 1 : 0;
    if (is_r) e.alu = (alt && (f3 == 0)) ? 1 : (alt && (f3 == 5)) ? 7 : r_tab[f3];
    else if (is_i) e.alu = (alt && (f3 == 5)) ? 7 : i_tab[f3];
    else if (is_lui) e.alu = 16;
    else if (is_jalr) e.alu = 17;
    else if (is_b) e.alu = (f3 <= 1) ? 1 : (f3 == 4 || f3 == 5) ? 3 : (f3 >= 6) ? 4 : 19;
    else e.alu = 0;
    if (is_b) begin
      e.cyc = fetch + 2;
      if (f3 == 2 || f3 == 3) begin e.trp = 1; return e; end
      e.pcn = 1;
      e.psel = (((f3[2] ? l : z) ^ f3[0]) != 0) ? 1 : 0;
      return e;
    end
    if (is_lw || is_sw) begin
      if (md >= TO) begin
        e.trp = 1; e.cyc = fetch + 2 + TO; e.dmn = TO; e.wen = is_sw ? TO : 0;
        return e;
      end
      e.dmn = md + 1;
      e.pcn = 1; e.psel = 0;
      if (is_sw) begin e.wen = md + 1; e.cyc = fetch + 2 + md + 1; return e; end
      e.cyc = fetch + 3 + md + 1; e.rfn = rd_nz; e.wb = 1;
      return e;
    end
    e.cyc = fetch + 3;
    e.pcn = 1;
    e.psel = is_jal ? 1 : is_jalr ? 2 : 0;
    e.rfn = rd_nz;
    e.wb = (is_jal || is_jalr) ? 2 : 0;
    return e;
  endfunction

  // Drives one instruction from FETCH (entered at posedge+1) until the FSM
  // returns to FETCH or traps; memories ack after fd / md request cycles.
  task automatic run_instr(input logic [31:0] ins, input int fd, input int md,
                           input bit z, input bit l, output res_t o);
    int fc = 0, mc = 0, guard = 0;
    bit left = 0, scramble = 0;
    o = blank();
    instr = ins; alu_zero = z; alu_lsb = l;
    forever begin
      imem_ack = 1'b0; dmem_ack = 1'b0;
      // Once the word is latched, the bus value must no longer matter.
      if (scramble) instr = $urandom();
      if (state == 3'd5) begin
        o.trp = 1;
        check("trap_pin", int'(trap), 1);
        check("trap_strobes", int'({imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we}), 0);
        break;
      end
      if (state == 3'd0 && left) break;
      if (guard >= 60) begin
        n_cmp++; n_err++;
        $display("FAIL cycle_budget: instr %08h still in state %0d after %0d cycles", ins, state, guard);
        break;
      end
      imem_ack = imem_req && (fc == fd);
      dmem_ack = dmem_req && (mc == md);
      @(negedge clk);
      o.cyc++;
      if (state != 3'd0) left = 1;
      if (state == 3'd2) begin o.alu = int'(alu_op); o.imm = int'(alu_src_imm); end
      if (state == 3'd4) o.wb = int'(wb_sel);
      if (pc_we) begin o.pcn++; o.psel = int'(pc_sel); end
      if (rf_we) o.rfn++;
      if (dmem_req) o.dmn++;
      if (dmem_we) o.wen++;
      if (ir_we) begin o.irn++; scramble = 1; end
      fc += int'(imem_req); mc += int'(dmem_req); guard++;
      @(posedge clk); #1;
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic compare(input string tag, input res_t a, input res_t e);
    check({tag, ".cycles"}, a.cyc, e.cyc);   check({tag, ".trap"}, a.trp, e.trp);
    check({tag, ".alu_op"}, a.alu, e.alu);   check({tag, ".src_imm"}, a.imm, e.imm);
    check({tag, ".pc_we_n"}, a.pcn, e.pcn);  check({tag, ".pc_sel"}, a.psel, e.psel);
    check({tag, ".rf_we_n"}, a.rfn, e.rfn);  check({tag, ".wb_sel"}, a.wb, e.wb);
    check({tag, ".dmem_n"}, a.dmn, e.dmn);   check({tag, ".dmem_we_n"}, a.wen, e.wen);
    check({tag, ".ir_we_n"}, a.irn, e.irn);
  endtask

  task automatic do_reset();
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] gen(int k);
    logic [31:0] r = $urandom();
    logic [2:0] f3 = 3'($urandom_range(0, 7));
    logic [6:0] f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    logic [6:0] op;
    case (k)
      0: return {r[31:12], r[11:7], 7'h37};
      1: return {r[31:12], r[11:7], 7'h17};
      2: return {r[31:12], r[11:7], 7'h6F};
      3: return {r[31:15], f3, r[11:7], 7'h63};
      4: return {r[31:15], 3'd2, r[11:7], 7'h03};
      5: return {r[31:15], 3'd0, r[11:7], 7'h67};
      6: return {f7, r[24:15], f3, r[11:7], 7'h13};
      7: return {r[31:15], 3'd2, r[11:7], 7'h23};
      8: return {f7, r[24:15], f3, r[11:7], 7'h33};
      9: return {r[31:7], 7'h73};
      default: begin
        op = r[6:0];
        if (op inside {7'h37, 7'h17, 7'h6F, 7'h63, 7'h03, 7'h67, 7'h13, 7'h23, 7'h33, 7'h73})
          op = 7'h7F;
        return {r[31:7], op};
      end
    endcase
  endfunction

  vec_t vt[18];
  res_t o, e;
  logic [31:0] ins;
  int fd, md, k;
  bit z, l;

  initial begin
    vt[0]  = mk(32'h003100B3, 0, 0, 0, 0, 4, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1);
    vt[1]  = mk(32'h0000A283, 0, 2, 0, 0, 7, 0, 0, 1, 1, 0, 1, 1, 3, 0, 1);
    vt[2]  = mk(32'h00000463, 0, 0, 1, 0, 3, 0, 1, 0, 1, 1, 0, 3, 0, 0, 1);
    vt[3]  = mk(32'h00000463, 0, 0, 0, 0, 3, 0, 1, 0, 1, 0, 0, 3, 0, 0, 1);
    vt[4]  = mk(32'h00000073, 0, 0, 0, 0, 2, 1, 63, 0, 0, 3, 0, 3, 0, 0, 1);
    vt[5]  = mk(32'h00310033, 0, 0, 0, 0, 4, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    vt[6]  = mk(32'h003100B3, 3, 0, 0, 0, 7, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1);
    vt[7]  = mk(32'h003100B3, 4, 0, 0, 0, 4, 1, 63, 0, 0, 3, 0, 3, 0, 0, 0);
    vt[8]  = mk(32'h0020A223, 0, 1, 0, 0, 5, 0, 0, 1, 1, 0, 0, 3, 2, 2, 1);
    vt[9]  = mk(32'h008000EF, 0, 0, 0, 0, 4, 0, 0, 0, 1, 1, 1, 2, 0, 0, 1);
    vt[10] = mk(32'h000100E7, 0, 0, 0, 0, 4, 0, 17, 1, 1, 2, 1, 2, 0, 0, 1);
    vt[11] = mk(32'h123452B7, 0, 0, 0, 0, 4, 0, 16, 1, 1, 0, 1, 0, 0, 0, 1);
    vt[12] = mk(32'h00006463, 0, 0, 0, 1, 3, 0, 4, 0, 1, 1, 0, 3, 0, 0, 1);
    vt[13] = mk(32'h00005463, 0, 0, 0, 1, 3, 0, 3, 0, 1, 0, 0, 3, 0, 0, 1);
    vt[14] = mk(32'h00002463, 0, 0, 0, 0, 3, 1, 19, 0, 0, 3, 0, 3, 0, 0, 1);
    vt[15] = mk(32'h0020A223, 0, 4, 0, 0, 7, 1, 0, 1, 0, 3, 0, 3, 4, 4, 1);
    vt[16] = mk(32'h40315093, 0, 0, 0, 0, 4, 0, 7, 1, 1, 0, 1, 0, 0, 0, 1);
    vt[17] = mk(32'h403100B3, 0, 0, 0, 0, 4, 0, 1, 0, 1, 0, 1, 0, 0, 0, 1);

    // Reset overrides a pending fetch ack; outputs show idle FETCH.
    rst = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b0; instr = '0; alu_zero = 0; alu_lsb = 0;
    @(posedge clk); #1 imem_ack = 1'b1;
    @(negedge clk);
    check("rst.state", int'(state), 0);        check("rst.imem_req", int'(imem_req), 1);
    check("rst.alu_op", int'(alu_op), 18);     check("rst.trap", int'(trap), 0);
    check("rst.strobes", int'({dmem_req, dmem_we, ir_we, rf_we, pc_we, alu_src_imm}), 0);
    check("rst.sels", int'({wb_sel, pc_sel}), 0);
    @(posedge clk); #1 imem_ack = 1'b0; rst = 1'b0;
    check("post_rst.state", int'(state), 0);   check("post_rst.imem_req", int'(imem_req), 1);
    $display("txn reset: state=%0d imem_req=%0d alu_op=%0d", state, imem_req, alu_op);

    for (int i = 0; i < 18; i++) begin
      run_instr(vt[i].ins, vt[i].fd, vt[i].md, vt[i].z, vt[i].l, o);
      compare($sformatf("vec%0d", i), o, vt[i].e);
      $display("txn vec%0d instr=%08h fd=%0d md=%0d cycles=%0d trap=%0d",
               i, vt[i].ins, vt[i].fd, vt[i].md, o.cyc, o.trp);
      if (o.trp) do_reset();
    end

    // TRAP is absorbing even with acks offered, and one reset cycle leaves it.
    run_instr(32'h00000073, 0, 0, 0, 0, o);
    check("ecall.trap", o.trp, 1);
    imem_ack = 1'b1; dmem_ack = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("absorb%0d.state", c), int'(state), 5);
      check($sformatf("absorb%0d.trap", c), int'(trap), 1);
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    check("trap_exit.state", int'(state), 0);  check("trap_exit.trap", int'(trap), 0);
    $display("txn trap_absorb: state after reset=%0d", state);

    // Reset in the middle of a data handshake.
    instr = 32'h0000A283; imem_ack = 1'b1;
    @(posedge clk); #1 imem_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("mid_mem.state", int'(state), 3);    check("mid_mem.dmem_req", int'(dmem_req), 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("mem_abort.state", int'(state), 0);  check("mem_abort.dmem_req", int'(dmem_req), 0);
    $display("txn mem_abort: state=%0d", state);

    // Reset after three unanswered fetch cycles must restart the wait count.
    instr = 32'h003100B3;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    run_instr(32'h003100B3, 3, 0, 0, 0, o);
    compare("wait_clear", o, model(32'h003100B3, 3, 0, 0, 0));
    $display("txn wait_clear: cycles=%0d trap=%0d", o.cyc, o.trp);
    if (o.trp) do_reset();

    for (int it = 0; it < 200; it++) begin
      k = $urandom_range(0, 10);
      ins = gen(k);
      fd = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 5);
      md = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 5);
      z = 1'($urandom_range(0, 1));
      l = 1'($urandom_range(0, 1));
      e = model(ins, fd, md, z, l);
      run_instr(ins, fd, md, z, l, o);
      compare($sformatf("rnd%0d", it), o, e);
      $display("txn rnd%0d instr=%08h fd=%0d md=%0d cycles=%0d trap=%0d",
               it, ins, fd, md, o.cyc, o.trp);
      if (o.trp) do_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/rv32i_ctrl_fsm.md
RV32I_CTRL_FSM -- requirements
Module: rv32i_ctrl_fsm

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: max wait cycles for imem_ack or dmem_ack before trapping (range 1..65535).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous to clk, active-high.
REQ-004 SHALL have port imem_req  output  1  instruction fetch request.
REQ-005 SHALL have port imem_ack  input  1  fetch complete; instr valid this cycle.
REQ-006 SHALL have port instr  input  32  fetched instruction word.
REQ-007 SHALL have port dmem_req  output  1  data memory request.
REQ-008 SHALL have port dmem_we  output  1  data write strobe (SW).
REQ-009 SHALL have port dmem_ack  input  1  data access complete.
REQ-010 SHALL have port alu_op  output  6  ALU operation, package alu_ops encoding (ADD=0 … INVALID=19).
REQ-011 SHALL have port alu_src_imm  output  1  ALU operand B select; 1 = immediate.
REQ-012 SHALL have port alu_zero, alu_lsb  input  1 each  ALU result ==0 and result bit 0.
REQ-013 SHALL have port ir_we  output  1  external instruction register load.
REQ-014 SHALL have port rf_we  output  1  register file write enable.
REQ-015 SHALL have port wb_sel  output  2  writeback source: 00 ALU, 01 memory, 10 PC+4.
REQ-016 SHALL have port pc_we  output  1  PC update enable.
REQ-017 SHALL have port pc_sel  output  2  next PC: 00 PC+4, 01 PC+imm, 10 ALU result (JALR).
REQ-018 SHALL have port state  output  3  current state: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, TRAP=5.
REQ-019 SHALL have port trap  output  1  high while in TRAP.

Function
REQ-020 SHALL be a Moore/Mealy FSM, states FETCH, DECODE, EXECUTE, MEM, WB, TRAP.
REQ-021 FETCH: imem_req=1 until imem_ack; on ack: latch instr internally, ir_we=1 same cycle, next DECODE.
REQ-022 DECODE: one cycle; classify opcode (LUI, AUIPC, JAL, B, LW, JALR, I, SW, R, SYSTEM); next EXECUTE, or TRAP for SYSTEM or unknown opcode.
REQ-023 EXECUTE alu_op: R from funct3/funct7[5] (ADD/SUB, SLL, SLT, SLTU, XOR, SRL/SRA, OR, AND); I from funct3 (ADDI, SLTI, SLTIU, XORI, ORI, ANDI; SLLI→SLL, SRLI/SRAI→SRL/SRA by funct7[5]); LW/SW→ADD; LUI→BYPASS; AUIPC, JAL→ADD; JALR→JALR; B: BEQ/BNE→SUB, BLT/BGE→SLT, BLTU/BGEU→SLTU; all other states NOP.
REQ-024 alu_src_imm=1 in EXECUTE for I, LW, SW, LUI, AUIPC, JALR; 0 otherwise.
REQ-025 EXECUTE next: R, I, LUI, AUIPC, JAL, JALR→WB; LW, SW→MEM; B→FETCH.
REQ-026 B in EXECUTE: taken = BEQ alu_zero, BNE !alu_zero, BLT/BLTU alu_lsb, BGE/BGEU !alu_lsb; pc_we=1, pc_sel=01 if taken else 00; undefined funct3 (010, 011)→TRAP, pc_we=0.
REQ-027 MEM: dmem_req=1, dmem_we=1 for SW, until dmem_ack; on ack SW→FETCH with pc_we=1, pc_sel=00; LW→WB.
REQ-028 WB: one cycle; rf_we=1 unless rd==0; wb_sel=01 LW, 10 JAL/JALR, 00 otherwise; pc_we=1, pc_sel=01 JAL, 10 JALR, 00 otherwise; next FETCH.
REQ-029 pc_we SHALL be asserted exactly once per retired instruction; rf_we at most once.
REQ-030 Wait counter: cleared on entry to FETCH/MEM; increments each cycle waiting without ack; reaching TIMEOUT_CYCLES without ack→TRAP. Ack on the same cycle as the limit takes priority.
REQ-031 TRAP: absorbing until rst; trap=1; all strobes (imem_req, dmem_req, dmem_we, ir_we, rf_we, pc_we) 0.
REQ-032 Latency with zero-wait acks: R/I/LUI/AUIPC/JAL/JALR 4 cycles, B 3, SW 4, LW 5.

Reset
REQ-033 rst=1 at a clock edge SHALL force FETCH, clear the wait counter and latched instruction, and override any state including TRAP or a pending memory handshake.
REQ-034 During and after reset: state=0, imem_req=1 (FETCH), trap=0, all other outputs 0, alu_op=NOP (18).

Verification
REQ-035 Fetch 0x003100B3 (ADD x1,x2,x3), immediate ack -> states 0,1,2,4; alu_op=0, alu_src_imm=0 in EXECUTE; rf_we=1, wb_sel=00, pc_we=1, pc_sel=00 in WB.
REQ-036 Fetch 0x0000A283 (LW x5,0(x1)), dmem_ack after 3 cycles -> alu_op=0 with alu_src_imm=1; dmem_req high 3 cycles, dmem_we=0; WB with wb_sel=01, rf_we=1.
REQ-037 Fetch 0x00000463 (BEQ x0,x0,+8), alu_zero=1 -> EXECUTE alu_op=1, pc_we=1, pc_sel=01, then FETCH; with alu_zero=0 -> pc_sel=00.
REQ-038 Fetch 0x00000073 (ECALL) -> DECODE→TRAP, trap=1, no pc_we; rst=1 for one cycle -> state=0, trap=0.
REQ-039 TIMEOUT_CYCLES=4, imem_ack held 0 -> TRAP after 4 waiting cycles; ack on the 4th cycle -> DECODE instead.
REQ-040 ADD with rd=0 (0x00310033) -> WB rf_we=0, pc_we=1.
